// File: rtl/arb_mux.sv
//------------------------------------------------------------------------------
// Module   : arb_mux
// Purpose  : Round-robin N:1 arbiter feeding a single registered output stage.
//            Full throughput (one beat per cycle) with valid/ready handshakes
//            on every input channel and on the output.
// Options  : define ARB_MUX_LOCK_EN to add the in_lock port, which lets a
//            channel hold the grant across several consecutive beats.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module arb_mux #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 8,
  parameter int IDW      = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
`ifdef ARB_MUX_LOCK_EN
  input  logic [CHANNELS-1:0]       in_lock,
`endif
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [IDW-1:0]            out_id
);

  localparam logic [IDW:0]   CH_EXT  = (IDW+1)'(CHANNELS);
  localparam logic [IDW-1:0] LAST_CH = IDW'(CHANNELS-1);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t               state;
  state_t               state_next;
  logic [IDW-1:0]       ptr;
  logic [IDW-1:0]       ptr_next;
  logic                 load;
  logic                 xfer;
  logic                 grant_found;
  logic [IDW-1:0]       grant_id;
  logic [IDW:0]         sum;
  logic [CHANNELS-1:0]  eligible;
  logic [CHANNELS-1:0]  rotated;
  logic [WIDTH-1:0]     grant_data;
`ifdef ARB_MUX_LOCK_EN
  logic                 lock_flag;
  logic                 grant_lock;
  logic [CHANNELS-1:0]  lock_mask;
`endif

  // The output register can take a new beat when empty or when it drains now.
  assign load      = (state == EMPTY) || out_ready;
  assign out_valid = (state == FULL);
  assign ptr_next  = (grant_id == LAST_CH) ? '0 : grant_id + 1'b1;

  // Requests allowed to compete; a held lock restricts them to the locked channel,
  // which is always the channel that sourced the beat currently in out_id.
  always_comb begin
`ifdef ARB_MUX_LOCK_EN
    lock_mask = '0;
    for (int i = 0; i < CHANNELS; i++) lock_mask[i] = (out_id == IDW'(i));
    eligible = lock_flag ? (in_valid & lock_mask) : in_valid;
`else
    eligible = in_valid;
`endif
  end

  // Round-robin pick: rotate requests so ptr lands at bit 0, take the lowest set bit.
  always_comb begin
    rotated     = CHANNELS'({eligible, eligible} >> ptr);
    grant_found = 1'b0;
    grant_id    = '0;
    sum         = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (!grant_found && rotated[k]) begin
        grant_found = 1'b1;
        sum         = {1'b0, ptr} + (IDW+1)'(k);
        if (sum >= CH_EXT) sum = sum - CH_EXT;
        grant_id    = sum[IDW-1:0];
      end
    end
  end

  // Handshake decode and payload select for the granted channel; reset blocks any accept.
  always_comb begin
    xfer       = rst_n && load && grant_found;
    in_ready   = '0;
    grant_data = '0;
`ifdef ARB_MUX_LOCK_EN
    grant_lock = 1'b0;
`endif
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant_id == IDW'(i)) begin
        in_ready[i] = xfer;
        grant_data  = in_data[i*WIDTH +: WIDTH];
`ifdef ARB_MUX_LOCK_EN
        grant_lock  = in_lock[i];
`endif
      end
    end
  end

  // Next state: a load always leaves us FULL; a drain without a load empties us.
  always_comb begin
    state_next = state;
    if (xfer)                            state_next = FULL;
    else if (state == FULL && out_ready) state_next = EMPTY;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_next;
  end

  // Output payload register; holds its value whenever nothing is loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_id   <= '0;
    end else if (xfer) begin
      out_data <= grant_data;
      out_id   <= grant_id;
    end
  end

  // Arbitration pointer (and lock flag) advance only on an input transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
`ifdef ARB_MUX_LOCK_EN
      lock_flag <= 1'b0;
`endif
    end else if (xfer) begin
`ifdef ARB_MUX_LOCK_EN
      if (!lock_flag || !grant_lock) ptr <= ptr_next;
      lock_flag <= grant_lock;
`else
      ptr       <= ptr_next;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_arb_mux.sv
//------------------------------------------------------------------------------
// Module   : tb_arb_mux
// Purpose  : Directed self-checking bench for arb_mux (8 channels, 32 bits).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_arb_mux;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   in_valid;
  logic [255:0] in_data;
  logic [7:0]   in_ready;
  logic [7:0]   in_lock;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic [2:0]   out_id;
  logic [31:0]  ch_data [8];

  int checks = 0;
  int errors = 0;

  arb_mux #(.WIDTH(32), .CHANNELS(8), .IDW(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
`ifdef ARB_MUX_LOCK_EN
    .in_lock   (in_lock),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id)
  );

  always #5 clk = ~clk;

  // Pack per-channel payloads onto the flat input bus.
  always_comb begin
    in_data = '0;
    for (int i = 0; i < 8; i++) in_data[i*32 +: 32] = ch_data[i];
  end

  function automatic logic [31:0] dat(input int i);
    dat = {24'hC0FFEE, 8'(i)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle starting at a falling edge: drive, check in_ready, clock, check outputs.
  task automatic beat(input string tag, input logic [7:0] v, input logic ordy,
                      input logic [7:0] exp_rdy, input logic exp_ov,
                      input logic [2:0] exp_id, input logic [31:0] exp_data);
    in_valid  = v;
    out_ready = ordy;
    #1;
    check({tag, "_rdy"}, in_ready, exp_rdy);
    @(posedge clk);
    #1;
    check({tag, "_ov"},   out_valid, exp_ov);
    check({tag, "_id"},   out_id,    exp_id);
    check({tag, "_data"}, out_data,  exp_data);
    @(negedge clk);
  endtask

  int          exp_ptr;
  int          last_g;
  int          served [8];
  logic [7:0]  rdy_v;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 8'hFF;
    out_ready = 1'b1;
    in_lock   = 8'h00;
    for (int i = 0; i < 8; i++) ch_data[i] = dat(i);

    // Reset state, with requests present that must not be accepted.
    @(negedge clk);
    #1;
    check("rst_ov",   out_valid, 1'b0);
    check("rst_data", out_data,  32'h0);
    check("rst_id",   out_id,    3'd0);
    check("rst_rdy",  in_ready,  8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Channels 0 and 2 alternate: 0, 2, 0.
    beat("rr0", 8'h05, 1'b1, 8'h01, 1'b1, 3'd0, dat(0));
    beat("rr1", 8'h05, 1'b1, 8'h04, 1'b1, 3'd2, dat(2));
    beat("rr2", 8'h05, 1'b1, 8'h01, 1'b1, 3'd0, dat(0));
    // Drain with no request: goes empty, payload holds.
    beat("drain0", 8'h00, 1'b1, 8'h00, 1'b0, 3'd0, dat(0));

    // Move ptr to 7, grant 7, then wrap: ch0 wins over ch7.
    beat("wrap6", 8'h40, 1'b1, 8'h40, 1'b1, 3'd6, dat(6));
    beat("wrap7", 8'h80, 1'b1, 8'h80, 1'b1, 3'd7, dat(7));
    beat("wrap0", 8'h81, 1'b1, 8'h01, 1'b1, 3'd0, dat(0));
    beat("drain1", 8'h00, 1'b1, 8'h00, 1'b0, 3'd0, dat(0));

    // Backpressure: FULL with DEADBEEF held for 5 cycles.
    ch_data[1] = 32'hDEADBEEF;
    beat("bp_load", 8'h02, 1'b1, 8'h02, 1'b1, 3'd1, 32'hDEADBEEF);
    for (int c = 0; c < 5; c++)
      beat("bp_hold", 8'hFF, 1'b0, 8'h00, 1'b1, 3'd1, 32'hDEADBEEF);
    ch_data[1] = dat(1);
    beat("bp_rel", 8'hFF, 1'b1, 8'h04, 1'b1, 3'd2, dat(2));

    // All channels valid, out_ready toggling: 8 grants, each channel once.
    exp_ptr = 3;
    last_g  = 2;
    for (int i = 0; i < 8; i++) served[i] = 0;
    for (int k = 0; k < 16; k++) begin
      if (k % 2 == 0) begin
        rdy_v = 8'h01 << exp_ptr;
        served[exp_ptr]++;
        last_g  = exp_ptr;
        exp_ptr = (exp_ptr + 1) % 8;
        beat("tog_go", 8'hFF, 1'b1, rdy_v, 1'b1, 3'(last_g), dat(last_g));
      end else begin
        beat("tog_hold", 8'hFF, 1'b0, 8'h00, 1'b1, 3'(last_g), dat(last_g));
      end
    end
    for (int i = 0; i < 8; i++) check("tog_served", 64'(served[i]), 64'd1);

    // Reset mid-cycle while FULL: clears without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ov",   out_valid, 1'b0);
    check("arst_data", out_data,  32'h0);
    check("arst_rdy",  in_ready,  8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    // Pointer restarted at 0 (it was 3 before the reset).
    beat("post_rst", 8'hFF, 1'b1, 8'h01, 1'b1, 3'd0, dat(0));

`ifdef ARB_MUX_LOCK_EN
    // Lock: ch3 holds the grant for three beats, then ch1.
    beat("lk_pre", 8'h02, 1'b1, 8'h02, 1'b1, 3'd1, dat(1));
    in_lock = 8'h08;
    beat("lk_a", 8'h0A, 1'b1, 8'h08, 1'b1, 3'd3, dat(3));
    beat("lk_b", 8'h0A, 1'b1, 8'h08, 1'b1, 3'd3, dat(3));
    in_lock = 8'h00;
    beat("lk_c", 8'h0A, 1'b1, 8'h08, 1'b1, 3'd3, dat(3));
    beat("lk_d", 8'h0A, 1'b1, 8'h02, 1'b1, 3'd1, dat(1));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
